// File: rtl/axi4stream_pkg.sv
// Shared definitions for the AXI4-Stream buffer pair (input buffer and output serializer).
package axi4stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned num_beats(input int unsigned axi_w, input int unsigned buf_w);
    return (buf_w + axi_w - 1) / axi_w;
  endfunction

  function automatic int unsigned last_packet_width(input int unsigned axi_w, input int unsigned buf_w);
    return buf_w - (num_beats(axi_w, buf_w) - 1) * axi_w;
  endfunction

endpackage

// File: rtl/axi4stream_output_serializer_if.sv
// Load-side and stream-side signals of the output serializer.
interface axi4stream_output_serializer_if #(
  parameter int unsigned AXI_WIDTH    = 32,
  parameter int unsigned BUFFER_WIDTH = 128
) ();
  logic [BUFFER_WIDTH-1:0] in_buffer;
  logic                    in_valid;
  logic                    in_ready;
  logic [AXI_WIDTH-1:0]    tdata;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;
  logic                    busy;

  modport master (
    input  in_buffer, in_valid, tready,
    output in_ready, tdata, tvalid, tlast, busy
  );

  modport slave (
    output in_buffer, in_valid, tready,
    input  in_ready, tdata, tvalid, tlast, busy
  );
endinterface

// File: rtl/buffer_slot.sv
// One wide word register with a full flag; load wins over clear.
module buffer_slot #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4stream_output_serializer.sv
// Splits each wide word into AXI4-Stream beats, LSB chunk first, with a one-deep
// pending slot so consecutive frames stream without bubbles.
module axi4stream_output_serializer
  import axi4stream_pkg::*;
#(
  parameter int unsigned AXI_WIDTH    = 32,
  parameter int unsigned BUFFER_WIDTH = 128
) (
  input logic                           aclk,
  input logic                           areset,
  axi4stream_output_serializer_if.master bus
);

  localparam int unsigned NUM_BEATS         = num_beats(AXI_WIDTH, BUFFER_WIDTH);
  localparam int unsigned LAST_PACKET_WIDTH = last_packet_width(AXI_WIDTH, BUFFER_WIDTH);
  localparam int unsigned IDXW              = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned PADW              = NUM_BEATS * AXI_WIDTH;

  if (BUFFER_WIDTH < AXI_WIDTH || NUM_BEATS > 256 ||
      LAST_PACKET_WIDTH < 1 || LAST_PACKET_WIDTH > AXI_WIDTH) begin : g_bad_params
    $error("axi4stream_output_serializer: invalid AXI_WIDTH/BUFFER_WIDTH combination");
  end

  // Zero-extending to a whole number of beats leaves the unused top bits of the last beat at zero.
  function automatic logic [AXI_WIDTH-1:0] chunk(input logic [BUFFER_WIDTH-1:0] w,
                                                 input logic [IDXW-1:0]         k);
    logic [PADW-1:0] p;
    p = '0;
    p[BUFFER_WIDTH-1:0] = w;
    return p[k*AXI_WIDTH +: AXI_WIDTH];
  endfunction

  state_t                  state;
  logic [IDXW-1:0]         beat_idx;
  logic [AXI_WIDTH-1:0]    tdata_r;
  logic                    tvalid_r, tlast_r, in_ready_r, busy_r;

  logic [BUFFER_WIDTH-1:0] act_q, pend_q, act_d;
  logic                    act_full, pend_full;
  logic                    load, xfer, last, frame_end, take_pend, direct;
  logic                    act_load, act_clr, pend_load, pend_clr, act_full_n, pend_full_n;

  always_comb begin
    load        = bus.in_valid & in_ready_r;
    xfer        = tvalid_r & bus.tready;
    last        = (beat_idx == IDXW'(NUM_BEATS - 1));
    frame_end   = xfer & last;
    take_pend   = frame_end & pend_full;
    // A load bypasses the pending slot when the active slot is empty or just finished.
    direct      = load & ((state == IDLE) | (frame_end & ~pend_full));
    act_load    = take_pend | direct;
    act_d       = take_pend ? pend_q : bus.in_buffer;
    act_clr     = frame_end & ~pend_full & ~load;
    pend_load   = load & ~direct;
    pend_clr    = take_pend;
    act_full_n  = act_load | (act_full & ~act_clr);
    pend_full_n = pend_load | (pend_full & ~pend_clr);
  end

  buffer_slot #(.WIDTH(BUFFER_WIDTH)) u_active (
    .clk  (aclk),
    .rst  (areset),
    .load (act_load),
    .clear(act_clr),
    .d    (act_d),
    .q    (act_q),
    .full (act_full)
  );

  buffer_slot #(.WIDTH(BUFFER_WIDTH)) u_pending (
    .clk  (aclk),
    .rst  (areset),
    .load (pend_load),
    .clear(pend_clr),
    .d    (bus.in_buffer),
    .q    (pend_q),
    .full (pend_full)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      beat_idx   <= '0;
      tdata_r    <= '0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      if (act_load) begin
        state    <= SEND;
        beat_idx <= '0;
        tdata_r  <= chunk(act_d, '0);
        tvalid_r <= 1'b1;
        tlast_r  <= (NUM_BEATS == 1);
      end else if (xfer && !last) begin
        beat_idx <= beat_idx + 1'b1;
        tdata_r  <= chunk(act_q, IDXW'(beat_idx + 1'b1));
        tlast_r  <= (IDXW'(beat_idx + 1'b1) == IDXW'(NUM_BEATS - 1));
      end else if (act_clr) begin
        state    <= IDLE;
        beat_idx <= '0;
        tdata_r  <= '0;
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
      end
      in_ready_r <= ~pend_full_n;
      busy_r     <= act_full_n | pend_full_n;
    end
  end

  assign bus.tdata    = tdata_r;
  assign bus.tvalid   = tvalid_r;
  assign bus.tlast    = tlast_r;
  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_axi4stream_output_serializer.sv
// Bench for the output serializer: directed scenarios plus random traffic against a frame-level model.
module tb_axi4stream_output_serializer;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi4stream_output_serializer_if #(.AXI_WIDTH(32), .BUFFER_WIDTH(80)) bus ();
  axi4stream_output_serializer_if #(.AXI_WIDTH(32), .BUFFER_WIDTH(32)) sb ();

  axi4stream_output_serializer #(.AXI_WIDTH(32), .BUFFER_WIDTH(80)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  axi4stream_output_serializer #(.AXI_WIDTH(32), .BUFFER_WIDTH(32)) dut1 (
    .aclk  (aclk),
    .areset(areset),
    .bus   (sb)
  );

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    outstanding = 0;  // words accepted whose last beat has not yet been transferred
  int    tests = 0;
  int    fails = 0;

  localparam logic [79:0] WA = 80'h1111_2222_3333_4444_5555;
  localparam logic [79:0] WB = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [79:0] w);
    logic [79:0] s;
    beat_t b;
    for (int unsigned k = 0; k < 3; k++) begin
      s      = w >> (32 * k);
      b.d    = s[31:0];
      b.last = (k == 2);
      q.push_back(b);
    end
    outstanding++;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance one clock.
  task automatic step(input logic v, input logic [79:0] w, input logic r);
    logic ld, xf;
    bus.in_valid  = v;
    bus.in_buffer = w;
    bus.tready    = r;
    chk("tvalid", {79'd0, bus.tvalid}, {79'd0, outstanding > 0});
    chk("in_ready", {79'd0, bus.in_ready}, {79'd0, outstanding < 2});
    chk("busy", {79'd0, bus.busy}, {79'd0, outstanding > 0});
    if (outstanding > 0 && q.size() > 0) begin
      chk("tdata", {48'd0, bus.tdata}, {48'd0, q[0].d});
      chk("tlast", {79'd0, bus.tlast}, {79'd0, q[0].last});
    end
    ld = v & bus.in_ready;
    xf = bus.tvalid & r;
    @(posedge aclk);
    #1;
    if (xf && q.size() > 0) begin
      if (q[0].last) outstanding--;
      void'(q.pop_front());
    end
    if (ld) push_word(w);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [79:0] rw;
    areset        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_buffer = '0;
    bus.tready    = 1'b0;
    sb.in_valid   = 1'b0;
    sb.in_buffer  = '0;
    sb.tready     = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;

    chk("rst_tvalid", {79'd0, bus.tvalid}, 80'd0);
    chk("rst_tlast", {79'd0, bus.tlast}, 80'd0);
    chk("rst_tdata", {48'd0, bus.tdata}, 80'd0);
    chk("rst_busy", {79'd0, bus.busy}, 80'd0);
    chk("rst_in_ready", {79'd0, bus.in_ready}, 80'd1);

    // Basic frame
    step(1'b1, WA, 1'b1);
    chk("t1_beat0", {48'd0, bus.tdata}, 80'h4444_5555);
    step(1'b0, '0, 1'b1);
    chk("t1_beat1", {48'd0, bus.tdata}, 80'h2222_3333);
    step(1'b0, '0, 1'b1);
    chk("t1_beat2", {48'd0, bus.tdata}, 80'h0000_1111);
    chk("t1_tlast", {79'd0, bus.tlast}, 80'd1);
    step(1'b0, '0, 1'b1);
    chk("t1_idle_tvalid", {79'd0, bus.tvalid}, 80'd0);
    chk("t1_idle_busy", {79'd0, bus.busy}, 80'd0);

    // Backpressure on beat 1
    step(1'b1, WA, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("t2_hold3", {48'd0, bus.tdata}, 80'h2222_3333);
    step(1'b0, '0, 1'b0);
    chk("t2_hold4", {48'd0, bus.tdata}, 80'h2222_3333);
    chk("t2_hold4_v", {79'd0, bus.tvalid}, 80'd1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t2_last6", {79'd0, bus.tlast}, 80'd1);
    chk("t2_last6_d", {48'd0, bus.tdata}, 80'h0000_1111);
    drain();

    // Back-to-back via the pending slot
    step(1'b1, WA, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, WB, 1'b1);
    chk("t3_in_ready3", {79'd0, bus.in_ready}, 80'd0);
    step(1'b0, '0, 1'b1);
    chk("t3_b_beat0", {48'd0, bus.tdata}, 80'hDDDD_EEEE);
    chk("t3_in_ready4", {79'd0, bus.in_ready}, 80'd1);
    drain();

    // Load on the cycle of the last transfer, pending empty
    step(1'b1, WA, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, WB, 1'b1);
    chk("t4_b_beat0", {48'd0, bus.tdata}, 80'hDDDD_EEEE);
    chk("t4_in_ready", {79'd0, bus.in_ready}, 80'd1);
    drain();

    // Reset mid-frame
    step(1'b1, WA, 1'b1);
    step(1'b0, '0, 1'b1);
    areset = 1'b1;
    #1;
    chk("t5_async_tvalid", {79'd0, bus.tvalid}, 80'd0);
    chk("t5_async_in_ready", {79'd0, bus.in_ready}, 80'd1);
    chk("t5_async_busy", {79'd0, bus.busy}, 80'd0);
    q.delete();
    outstanding = 0;
    @(posedge aclk);
    #2;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    step(1'b1, WB, 1'b1);
    chk("t5_reload_beat0", {48'd0, bus.tdata}, 80'hDDDD_EEEE);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("t5_reload_tlast", {79'd0, bus.tlast}, 80'd1);
    drain();

    // Random traffic against the frame-level model
    for (int i = 0; i < 400; i++) begin
      rw = {$urandom, $urandom, $urandom};
      step(($urandom_range(0, 99) < 40), rw, ($urandom_range(0, 99) < 65));
    end
    drain();
    chk("rand_drained", {79'd0, bus.busy}, 80'd0);

    // Single-beat configuration, two words back-to-back
    sb.in_buffer = 32'hDEAD_BEEF;
    sb.in_valid  = 1'b1;
    sb.tready    = 1'b1;
    @(posedge aclk);
    #1;
    chk("t6_beat0", {48'd0, sb.tdata}, 80'hDEAD_BEEF);
    chk("t6_tlast0", {79'd0, sb.tlast}, 80'd1);
    chk("t6_in_ready", {79'd0, sb.in_ready}, 80'd1);
    @(posedge aclk);
    #1;
    sb.in_valid = 1'b0;
    chk("t6_beat1_v", {79'd0, sb.tvalid}, 80'd1);
    chk("t6_beat1", {48'd0, sb.tdata}, 80'hDEAD_BEEF);
    chk("t6_tlast1", {79'd0, sb.tlast}, 80'd1);
    @(posedge aclk);
    #1;
    chk("t6_idle", {79'd0, sb.tvalid}, 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
